// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: distributes sync-tagged slot words 0..3 onto
// channels a..d, updating all four atomically per frame with framing-error detection.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             err
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             out_valid_q, out_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  // Next-state: slot capture, frame commit and framing-error handling
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    out_valid_d = 1'b0;
    err_d       = err_q & ~err_clr;

    case (state_q)
      HUNT: begin
        if (in_valid && in_sync) begin
          sh0_d   = in_data;
          sel_d   = 2'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (in_sync) begin
            // A sync beat always restarts the frame; it is an error unless slot 0 was due
            if (sel_q != 2'd0) err_d = 1'b1;
            sh0_d = in_data;
            sel_d = 2'd1;
          end else if (sel_q == 2'd0) begin
            err_d   = 1'b1;
            state_d = HUNT;
            sel_d   = 2'd0;
          end else begin
            case (sel_q)
              2'd1:    sh1_d = in_data;
              2'd2:    sh2_d = in_data;
              default: begin
                a_d         = sh0_q;
                b_d         = sh1_q;
                c_d         = sh2_q;
                d_d         = in_data;
                out_valid_d = 1'b1;
              end
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = HUNT;
        sel_d   = 2'd0;
      end
    endcase

    locked_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      sel_q       <= 2'd0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign d         = d_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed, table-driven bench for tdm_demux4: each record is one clocked beat
// with the hand-computed register state expected after that edge.
module tb_tdm_demux4;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] in_data;
  logic             err_clr;
  logic [WIDTH-1:0] a, b, c, d;
  logic             out_valid;
  logic [1:0]       sel;
  logic             locked;
  logic             err;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_data  (in_data),
    .err_clr  (err_clr),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .out_valid(out_valid),
    .sel      (sel),
    .locked   (locked),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] din;
    logic       clr;
    logic [7:0] ea, eb, ec, ed;
    logic       eov;
    logic [1:0] esel;
    logic       elk;
    logic       eerr;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   split = 0;

  function automatic void add(input logic v, input logic s, input logic [7:0] din,
                              input logic clr, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ec, input logic [7:0] ed, input logic eov,
                              input logic [1:0] esel, input logic elk, input logic eerr);
    vec_t t;
    t.v = v; t.s = s; t.din = din; t.clr = clr;
    t.ea = ea; t.eb = eb; t.ec = ec; t.ed = ed;
    t.eov = eov; t.esel = esel; t.elk = elk; t.eerr = eerr;
    vq.push_back(t);
  endfunction

  task automatic check(input string name, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] ec, input logic [7:0] ed, input logic eov,
                       input logic [1:0] esel, input logic elk, input logic eerr);
    total++;
    if ({a, b, c, d, out_valid, sel, locked, err} !== {ea, eb, ec, ed, eov, esel, elk, eerr}) begin
      bad++;
      $display("FAIL %s: got a=%h b=%h c=%h d=%h ov=%b sel=%0d lk=%b err=%b, want a=%h b=%h c=%h d=%h ov=%b sel=%0d lk=%b err=%b",
               name, a, b, c, d, out_valid, sel, locked, err, ea, eb, ec, ed, eov, esel, elk, eerr);
    end
  endtask

  // Drives one record at the falling edge, checks just after the rising edge.
  task automatic apply(input int idx);
    vec_t t;
    t = vq[idx];
    in_valid = t.v;
    in_sync  = t.s;
    in_data  = t.din;
    err_clr  = t.clr;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", idx), t.ea, t.eb, t.ec, t.ed, t.eov, t.esel, t.elk, t.eerr);
    @(negedge clk);
  endtask

  initial begin
    // Single frame
    add(1, 1, 8'h11, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd1, 1, 0);
    add(1, 0, 8'h22, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd2, 1, 0);
    add(1, 0, 8'h33, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd3, 1, 0);
    add(1, 0, 8'h44, 0, 8'h11, 8'h22, 8'h33, 8'h44, 1, 2'd0, 1, 0);
    // Back-to-back frames
    add(1, 1, 8'h01, 0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 2'd1, 1, 0);
    add(1, 0, 8'h02, 0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 2'd2, 1, 0);
    add(1, 0, 8'h03, 0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 2'd3, 1, 0);
    add(1, 0, 8'h04, 0, 8'h01, 8'h02, 8'h03, 8'h04, 1, 2'd0, 1, 0);
    add(1, 1, 8'h05, 0, 8'h01, 8'h02, 8'h03, 8'h04, 0, 2'd1, 1, 0);
    add(1, 0, 8'h06, 0, 8'h01, 8'h02, 8'h03, 8'h04, 0, 2'd2, 1, 0);
    add(1, 0, 8'h07, 0, 8'h01, 8'h02, 8'h03, 8'h04, 0, 2'd3, 1, 0);
    add(1, 0, 8'h08, 0, 8'h05, 8'h06, 8'h07, 8'h08, 1, 2'd0, 1, 0);
    // Frame with idle gaps; idle beats carry junk with in_sync high
    add(1, 1, 8'h21, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd1, 1, 0);
    add(0, 1, 8'hFF, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd1, 1, 0);
    add(1, 0, 8'h22, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd2, 1, 0);
    add(0, 1, 8'hFF, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd2, 1, 0);
    add(0, 0, 8'hEE, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd2, 1, 0);
    add(1, 0, 8'h23, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd3, 1, 0);
    add(0, 1, 8'hFF, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd3, 1, 0);
    add(0, 0, 8'hEE, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd3, 1, 0);
    add(0, 1, 8'hDD, 0, 8'h05, 8'h06, 8'h07, 8'h08, 0, 2'd3, 1, 0);
    add(1, 0, 8'h24, 0, 8'h21, 8'h22, 8'h23, 8'h24, 1, 2'd0, 1, 0);
    // Early sync restarts the frame, stays locked
    add(1, 1, 8'hA0, 0, 8'h21, 8'h22, 8'h23, 8'h24, 0, 2'd1, 1, 0);
    add(1, 0, 8'hA1, 0, 8'h21, 8'h22, 8'h23, 8'h24, 0, 2'd2, 1, 0);
    add(1, 1, 8'hB0, 0, 8'h21, 8'h22, 8'h23, 8'h24, 0, 2'd1, 1, 1);
    add(1, 0, 8'hB1, 0, 8'h21, 8'h22, 8'h23, 8'h24, 0, 2'd2, 1, 1);
    add(1, 0, 8'hB2, 0, 8'h21, 8'h22, 8'h23, 8'h24, 0, 2'd3, 1, 1);
    add(1, 0, 8'hB3, 0, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1, 2'd0, 1, 1);
    add(0, 0, 8'h00, 1, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0, 2'd0, 1, 0);
    // Missing sync drops to HUNT; recovery; clear-vs-set priority
    add(1, 1, 8'h40, 0, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0, 2'd1, 1, 0);
    add(1, 0, 8'h41, 0, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0, 2'd2, 1, 0);
    add(1, 0, 8'h42, 0, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0, 2'd3, 1, 0);
    add(1, 0, 8'h43, 0, 8'h40, 8'h41, 8'h42, 8'h43, 1, 2'd0, 1, 0);
    add(1, 0, 8'h55, 0, 8'h40, 8'h41, 8'h42, 8'h43, 0, 2'd0, 0, 1);
    add(0, 0, 8'h00, 0, 8'h40, 8'h41, 8'h42, 8'h43, 0, 2'd0, 0, 1);
    add(1, 1, 8'h60, 0, 8'h40, 8'h41, 8'h42, 8'h43, 0, 2'd1, 1, 1);
    add(1, 0, 8'h61, 0, 8'h40, 8'h41, 8'h42, 8'h43, 0, 2'd2, 1, 1);
    add(1, 0, 8'h62, 0, 8'h40, 8'h41, 8'h42, 8'h43, 0, 2'd3, 1, 1);
    add(1, 0, 8'h63, 0, 8'h60, 8'h61, 8'h62, 8'h63, 1, 2'd0, 1, 1);
    add(0, 0, 8'h00, 1, 8'h60, 8'h61, 8'h62, 8'h63, 0, 2'd0, 1, 0);
    add(1, 0, 8'h70, 1, 8'h60, 8'h61, 8'h62, 8'h63, 0, 2'd0, 0, 1);
    add(1, 0, 8'h71, 0, 8'h60, 8'h61, 8'h62, 8'h63, 0, 2'd0, 0, 1);
    // Partial frame, interrupted by reset below
    add(1, 1, 8'h80, 0, 8'h60, 8'h61, 8'h62, 8'h63, 0, 2'd1, 1, 1);
    add(1, 0, 8'h81, 0, 8'h60, 8'h61, 8'h62, 8'h63, 0, 2'd2, 1, 1);
    split = vq.size();
    // After reset: unsynced beats ignored until a sync beat
    add(1, 0, 8'h82, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
    add(1, 0, 8'h83, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
    add(0, 1, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
    add(1, 1, 8'h90, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd1, 1, 0);
    add(1, 0, 8'h91, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd2, 1, 0);
    add(1, 0, 8'h92, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd3, 1, 0);
    add(1, 0, 8'h93, 0, 8'h90, 8'h91, 8'h92, 8'h93, 1, 2'd0, 1, 0);
    add(0, 0, 8'h00, 0, 8'h90, 8'h91, 8'h92, 8'h93, 0, 2'd0, 1, 0);

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < split; i++) apply(i);

    // Asynchronous reset mid-frame: outputs clear without a clock edge
    in_valid = 1'b0;
    in_sync  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = split; i < vq.size(); i++) apply(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
